// File: rtl/ahb_burst_length_tracker_pkg.sv
// Shared types and burst-length helpers for the AHB burst length tracker.
package ahb_len_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } hburst_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic [4:0] LEN_SINGLE = 5'd1;
  localparam logic [4:0] LEN_4      = 5'd4;
  localparam logic [4:0] LEN_8      = 5'd8;
  localparam logic [4:0] LEN_16     = 5'd16;

  // Beat count of a fixed-length burst; undefined-length INCR reports 0.
  function automatic logic [4:0] burst_len(input hburst_t b);
    case (b)
      BURST_SINGLE:              burst_len = LEN_SINGLE;
      BURST_WRAP4,  BURST_INCR4: burst_len = LEN_4;
      BURST_WRAP8,  BURST_INCR8: burst_len = LEN_8;
      BURST_WRAP16, BURST_INCR16: burst_len = LEN_16;
      default:                   burst_len = 5'd0;
    endcase
  endfunction

  function automatic logic is_wrap(input hburst_t b);
    is_wrap = (b == BURST_WRAP4) || (b == BURST_WRAP8) || (b == BURST_WRAP16);
  endfunction

  // Byte span of a whole fixed-length burst (0 for INCR).
  function automatic logic [11:0] burst_span(input hburst_t b, input logic [7:0] bytes);
    burst_span = 12'(burst_len(b)) * 12'(bytes);
  endfunction

endpackage

// File: rtl/ahb_burst_length_tracker_if.sv
// Bus-side signal bundle: AHB address-phase inputs plus tracker status outputs.
interface ahb_burst_length_tracker_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [1:0]            HTRANS;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HREADY;

  logic [7:0]            BEAT_BYTES;
  logic [ADDR_WIDTH-1:0] NEXT_ADDR;
  logic [4:0]            BEAT_CNT;
  logic [4:0]            BEATS_LEFT;
  logic [11:0]           TOTAL_BYTES;
  logic                  BURST_ACTIVE;
  logic                  BURST_LAST;
  logic                  SIZE_ERR;
  logic                  SEQ_ERR;

  modport slave (
    input  HTRANS, HSIZE, HBURST, HADDR, HREADY,
    output BEAT_BYTES, NEXT_ADDR, BEAT_CNT, BEATS_LEFT, TOTAL_BYTES,
           BURST_ACTIVE, BURST_LAST, SIZE_ERR, SEQ_ERR
  );

  modport master (
    output HTRANS, HSIZE, HBURST, HADDR, HREADY,
    input  BEAT_BYTES, NEXT_ADDR, BEAT_CNT, BEATS_LEFT, TOTAL_BYTES,
           BURST_ACTIVE, BURST_LAST, SIZE_ERR, SEQ_ERR
  );
endinterface

// File: rtl/ahb_burst_length_tracker_size_decoder.sv
// Maps HSIZE to bytes per beat, clamped to the bus width, with an oversize flag.
module ahb_size_decoder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0] hsize,
  output logic [7:0] beat_bytes,
  output logic       size_err
);
  localparam logic [7:0] MAX_BYTES = 8'(DATA_WIDTH / 8);

  logic [7:0] raw_bytes;

  // 2^HSIZE always fits in 8 bits (max 128); clamp when wider than the bus.
  always_comb begin
    raw_bytes  = 8'd1 << hsize;
    size_err   = (raw_bytes > MAX_BYTES);
    beat_bytes = size_err ? MAX_BYTES : raw_bytes;
  end
endmodule

// File: rtl/ahb_burst_length_tracker.sv
// Tracks beat count, remaining beats and next-beat address of AHB bursts.
module ahb_burst_length_tracker
  import ahb_len_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  ahb_burst_length_tracker_if.slave   bus
);

  state_t                state_q,       state_d;
  hburst_t               burst_q,       burst_d;
  logic [7:0]            beat_bytes_q,  beat_bytes_d;
  logic [ADDR_WIDTH-1:0] next_addr_q,   next_addr_d;
  logic [4:0]            beat_cnt_q,    beat_cnt_d;
  logic [4:0]            beats_left_q,  beats_left_d;
  logic [11:0]           total_bytes_q, total_bytes_d;
  logic                  burst_last_q,  burst_last_d;
  logic                  size_err_q,    size_err_d;
  logic                  seq_err_q,     seq_err_d;

  logic [7:0]            dec_bytes;
  logic                  dec_err;
  hburst_t               hburst_in;

  assign hburst_in = hburst_t'(bus.HBURST);

  ahb_size_decoder #(.DATA_WIDTH(DATA_WIDTH)) u_size_dec (
    .hsize      (bus.HSIZE),
    .beat_bytes (dec_bytes),
    .size_err   (dec_err)
  );

  // Address of the beat after addr: linear for INCR/SINGLE, wrapped at the burst span for WRAP.
  function automatic logic [ADDR_WIDTH-1:0] calc_next(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            bytes,
    input hburst_t               b
  );
    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] mask;
    inc  = addr + ADDR_WIDTH'(bytes);
    mask = ADDR_WIDTH'(burst_span(b, bytes)) - ADDR_WIDTH'(1);
    if (is_wrap(b)) calc_next = (addr & ~mask) | (inc & mask);
    else            calc_next = inc;
  endfunction

  // Next-state logic: only accepted transfers (HREADY high) change context; error flags are one-shot.
  always_comb begin
    state_d       = state_q;
    burst_d       = burst_q;
    beat_bytes_d  = beat_bytes_q;
    next_addr_d   = next_addr_q;
    beat_cnt_d    = beat_cnt_q;
    beats_left_d  = beats_left_q;
    total_bytes_d = total_bytes_q;
    size_err_d    = 1'b0;
    seq_err_d     = 1'b0;

    if (bus.HREADY) begin
      case (htrans_t'(bus.HTRANS))
        TRANS_NONSEQ: begin
          state_d       = ST_ACTIVE;
          burst_d       = hburst_in;
          beat_bytes_d  = dec_bytes;
          size_err_d    = dec_err;
          beat_cnt_d    = 5'd1;
          beats_left_d  = (hburst_in == BURST_INCR) ? 5'd0 : burst_len(hburst_in) - 5'd1;
          total_bytes_d = burst_span(hburst_in, dec_bytes);
          next_addr_d   = calc_next(bus.HADDR, dec_bytes, hburst_in);
        end
        TRANS_SEQ: begin
          // In ACTIVE with burst_last clear, either INCR or beats remain.
          if (state_q == ST_IDLE || burst_last_q) begin
            seq_err_d = 1'b1;
          end else begin
            if (burst_q == BURST_INCR) begin
              if (beat_cnt_q != 5'd31) beat_cnt_d = beat_cnt_q + 5'd1;
            end else begin
              beat_cnt_d   = beat_cnt_q + 5'd1;
              beats_left_d = beats_left_q - 5'd1;
            end
            next_addr_d = calc_next(bus.HADDR, beat_bytes_q, burst_q);
          end
        end
        TRANS_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          // BUSY holds everything.
        end
      endcase
    end

    burst_last_d = (state_d == ST_ACTIVE) && (burst_d != BURST_INCR) && (beats_left_d == 5'd0);
  end

  // Burst context registers; async reset clears every output.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= ST_IDLE;
      burst_q       <= BURST_SINGLE;
      beat_bytes_q  <= '0;
      next_addr_q   <= '0;
      beat_cnt_q    <= '0;
      beats_left_q  <= '0;
      total_bytes_q <= '0;
      burst_last_q  <= 1'b0;
      size_err_q    <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      burst_q       <= burst_d;
      beat_bytes_q  <= beat_bytes_d;
      next_addr_q   <= next_addr_d;
      beat_cnt_q    <= beat_cnt_d;
      beats_left_q  <= beats_left_d;
      total_bytes_q <= total_bytes_d;
      burst_last_q  <= burst_last_d;
      size_err_q    <= size_err_d;
      seq_err_q     <= seq_err_d;
    end
  end

  assign bus.BEAT_BYTES   = beat_bytes_q;
  assign bus.NEXT_ADDR    = next_addr_q;
  assign bus.BEAT_CNT     = beat_cnt_q;
  assign bus.BEATS_LEFT   = beats_left_q;
  assign bus.TOTAL_BYTES  = total_bytes_q;
  assign bus.BURST_ACTIVE = (state_q == ST_ACTIVE);
  assign bus.BURST_LAST   = burst_last_q;
  assign bus.SIZE_ERR     = size_err_q;
  assign bus.SEQ_ERR      = seq_err_q;

endmodule

// File: tb/tb_ahb_burst_length_tracker.sv
// Directed scoreboard bench for ahb_burst_length_tracker (DATA_WIDTH=32).
module tb_ahb_burst_length_tracker;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000, B_INCR = 3'b001, B_WRAP4 = 3'b010,
                         B_INCR4 = 3'b011, B_WRAP8 = 3'b100, B_INCR8 = 3'b101;

  typedef struct packed {
    logic [7:0]  bb;
    logic [31:0] na;
    logic [4:0]  cnt;
    logic [4:0]  left;
    logic [11:0] tot;
    logic        act;
    logic        last;
    logic        serr;
    logic        qerr;
  } exp_t;

  typedef struct packed {
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] addr;
    logic        ready;
    exp_t        e;
  } stim_t;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  ahb_burst_length_tracker_if #(.ADDR_WIDTH(32)) bus ();

  ahb_burst_length_tracker #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  function automatic exp_t mk(input int bb, input logic [31:0] na, input int cnt, input int left,
                              input int tot, input logic act, input logic last,
                              input logic serr, input logic qerr);
    exp_t e;
    e.bb = 8'(bb); e.na = na; e.cnt = 5'(cnt); e.left = 5'(left); e.tot = 12'(tot);
    e.act = act; e.last = last; e.serr = serr; e.qerr = qerr;
    return e;
  endfunction

  function automatic stim_t st(input logic [1:0] t, input logic [2:0] s, input logic [2:0] b,
                               input logic [31:0] a, input logic r, input exp_t e);
    stim_t x;
    x.trans = t; x.size = s; x.burst = b; x.addr = a; x.ready = r; x.e = e;
    return x;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.bb = bus.BEAT_BYTES; o.na = bus.NEXT_ADDR; o.cnt = bus.BEAT_CNT; o.left = bus.BEATS_LEFT;
    o.tot = bus.TOTAL_BYTES; o.act = bus.BURST_ACTIVE; o.last = bus.BURST_LAST;
    o.serr = bus.SIZE_ERR; o.qerr = bus.SEQ_ERR;
    return o;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("bb=%0d na=%h cnt=%0d left=%0d tot=%0d act=%b last=%b serr=%b qerr=%b",
                     e.bb, e.na, e.cnt, e.left, e.tot, e.act, e.last, e.serr, e.qerr);
  endfunction

  // Drive one address phase at the falling edge and return just after the next rising edge.
  task automatic apply(input logic [1:0] t, input logic [2:0] s, input logic [2:0] b,
                       input logic [31:0] a, input logic r);
    @(negedge HCLK);
    bus.HTRANS = t; bus.HSIZE = s; bus.HBURST = b; bus.HADDR = a; bus.HREADY = r;
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    stim_t tbl[$];
    exp_t  exp, obs;
    obs = observe();
    if (obs !== mk(0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      n_bad++;
      $display("FAIL reset_state: got %s, required all zero", fmt(obs));
    end
    n_cmp++;
    @(negedge HCLK);
    HRESETn = 1'b1;
    tbl.push_back(st(T_NSEQ, 3'd2, B_INCR8, 32'h200, 1'b1, mk(4, 32'h204, 1, 7, 32, 1, 0, 0, 0)));
    tbl.push_back(st(T_SEQ,  3'd2, B_INCR8, 32'h204, 1'b1, mk(4, 32'h208, 2, 6, 32, 1, 0, 0, 0)));
    tbl.push_back(st(T_SEQ,  3'd2, B_INCR8, 32'h208, 1'b1, mk(4, 32'h20C, 3, 5, 32, 1, 0, 0, 0)));
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].e);
      apply(tbl[i].trans, tbl[i].size, tbl[i].burst, tbl[i].addr, tbl[i].ready);
      exp = exp_q.pop_front();
      obs = observe();
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL reset_incr8[%0d]: got %s, required %s", i, fmt(obs), fmt(exp));
      end
      n_cmp++;
    end
    // Mid-cycle assertion: outputs must clear without waiting for a clock edge.
    @(negedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    obs = observe();
    if (obs !== mk(0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
      n_bad++;
      $display("FAIL reset_async: got %s, required all zero", fmt(obs));
    end
    n_cmp++;
    @(negedge HCLK);
    HRESETn = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(T_IDLE, 3'd2, B_INCR8, 32'h0, 1'b1);
    exp = exp_q.pop_front();
    obs = observe();
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL reset_release_idle: got %s, required %s", fmt(obs), fmt(exp));
    end
    n_cmp++;
  endtask

  task automatic test_incr4();
    stim_t tbl[$];
    exp_t  exp, obs;
    tbl.push_back(st(T_NSEQ, 3'd2, B_INCR4, 32'h100, 1'b1, mk(4, 32'h104, 1, 3, 16, 1, 0, 0, 0)));
    tbl.push_back(st(T_SEQ,  3'd2, B_INCR4, 32'h104, 1'b1, mk(4, 32'h108, 2, 2, 16, 1, 0, 0, 0)));
    tbl.push_back(st(T_SEQ,  3'd2, B_INCR4, 32'h108, 1'b1, mk(4, 32'h10C, 3, 1, 16, 1, 0, 0, 0)));
    tbl.push_back(st(T_SEQ,  3'd2, B_INCR4, 32'h10C, 1'b1, mk(4, 32'h110, 4, 0, 16, 1, 1, 0, 0)));
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].e);
      apply(tbl[i].trans, tbl[i].size, tbl[i].burst, tbl[i].addr, tbl[i].ready);
      exp = exp_q.pop_front();
      obs = observe();
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL incr4[%0d]: got %s, required %s", i, fmt(obs), fmt(exp));
      end
      n_cmp++;
    end
    apply(T_IDLE, 3'd2, B_INCR4, 32'h0, 1'b1);
    if ({bus.BURST_ACTIVE, bus.BURST_LAST} !== 2'b00) begin
      n_bad++;
      $display("FAIL incr4_to_idle: got act/last=%b%b, required 00", bus.BURST_ACTIVE, bus.BURST_LAST);
    end
    n_cmp++;
  endtask

  task automatic test_wrap4();
    stim_t tbl[$];
    exp_t  exp, obs;
    tbl.push_back(st(T_NSEQ, 3'd2, B_WRAP4, 32'h38, 1'b1, mk(4, 32'h3C, 1, 3, 16, 1, 0, 0, 0)));
    tbl.push_back(st(T_SEQ,  3'd2, B_WRAP4, 32'h3C, 1'b1, mk(4, 32'h30, 2, 2, 16, 1, 0, 0, 0)));
    tbl.push_back(st(T_SEQ,  3'd2, B_WRAP4, 32'h30, 1'b1, mk(4, 32'h34, 3, 1, 16, 1, 0, 0, 0)));
    tbl.push_back(st(T_SEQ,  3'd2, B_WRAP4, 32'h34, 1'b1, mk(4, 32'h38, 4, 0, 16, 1, 1, 0, 0)));
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].e);
      apply(tbl[i].trans, tbl[i].size, tbl[i].burst, tbl[i].addr, tbl[i].ready);
      exp = exp_q.pop_front();
      obs = observe();
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL wrap4[%0d]: got %s, required %s", i, fmt(obs), fmt(exp));
      end
      n_cmp++;
    end
    apply(T_IDLE, 3'd2, B_WRAP4, 32'h0, 1'b1);
  endtask

  task automatic test_size_err();
    stim_t tbl[$];
    exp_t  exp, obs;
    // 8-byte beat on a 32-bit bus clamps to 4; SINGLE is last on its only beat.
    tbl.push_back(st(T_NSEQ, 3'd3, B_SINGLE, 32'h40, 1'b1, mk(4, 32'h44, 1, 0, 4, 1, 1, 1, 0)));
    tbl.push_back(st(T_BUSY, 3'd3, B_SINGLE, 32'h44, 1'b1, mk(4, 32'h44, 1, 0, 4, 1, 1, 0, 0)));
    tbl.push_back(st(T_SEQ,  3'd3, B_SINGLE, 32'h44, 1'b1, mk(4, 32'h44, 1, 0, 4, 1, 1, 0, 1)));
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].e);
      apply(tbl[i].trans, tbl[i].size, tbl[i].burst, tbl[i].addr, tbl[i].ready);
      exp = exp_q.pop_front();
      obs = observe();
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL size_err[%0d]: got %s, required %s", i, fmt(obs), fmt(exp));
      end
      n_cmp++;
    end
    apply(T_IDLE, 3'd2, B_SINGLE, 32'h0, 1'b1);
  endtask

  task automatic test_busy_stall();
    stim_t tbl[$];
    exp_t  exp, obs;
    tbl.push_back(st(T_NSEQ, 3'd2, B_INCR4, 32'h100, 1'b1, mk(4, 32'h104, 1, 3, 16, 1, 0, 0, 0)));
    tbl.push_back(st(T_SEQ,  3'd2, B_INCR4, 32'h104, 1'b1, mk(4, 32'h108, 2, 2, 16, 1, 0, 0, 0)));
    tbl.push_back(st(T_BUSY, 3'd2, B_INCR4, 32'h108, 1'b1, mk(4, 32'h108, 2, 2, 16, 1, 0, 0, 0)));
    tbl.push_back(st(T_SEQ,  3'd2, B_INCR4, 32'h108, 1'b0, mk(4, 32'h108, 2, 2, 16, 1, 0, 0, 0)));
    tbl.push_back(st(T_NSEQ, 3'd0, B_WRAP8, 32'h300, 1'b0, mk(4, 32'h108, 2, 2, 16, 1, 0, 0, 0)));
    tbl.push_back(st(T_SEQ,  3'd2, B_INCR4, 32'h108, 1'b1, mk(4, 32'h10C, 3, 1, 16, 1, 0, 0, 0)));
    tbl.push_back(st(T_SEQ,  3'd2, B_INCR4, 32'h10C, 1'b1, mk(4, 32'h110, 4, 0, 16, 1, 1, 0, 0)));
    tbl.push_back(st(T_SEQ,  3'd2, B_INCR4, 32'h110, 1'b1, mk(4, 32'h110, 4, 0, 16, 1, 1, 0, 1)));
    tbl.push_back(st(T_BUSY, 3'd2, B_INCR4, 32'h110, 1'b1, mk(4, 32'h110, 4, 0, 16, 1, 1, 0, 0)));
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].e);
      apply(tbl[i].trans, tbl[i].size, tbl[i].burst, tbl[i].addr, tbl[i].ready);
      exp = exp_q.pop_front();
      obs = observe();
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL busy_stall[%0d]: got %s, required %s", i, fmt(obs), fmt(exp));
      end
      n_cmp++;
    end
    apply(T_IDLE, 3'd2, B_INCR4, 32'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    stim_t tbl[$];
    exp_t  exp, obs;
    // INCR wraps modulo 2^32; a NONSEQ mid-burst restarts as WRAP8 of halfwords.
    tbl.push_back(st(T_NSEQ, 3'd2, B_INCR,  32'hFFFF_FFFC, 1'b1, mk(4, 32'h0, 1, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(st(T_SEQ,  3'd2, B_INCR,  32'h0,         1'b1, mk(4, 32'h4, 2, 0, 0, 1, 0, 0, 0)));
    tbl.push_back(st(T_NSEQ, 3'd1, B_WRAP8, 32'h0E,        1'b1, mk(2, 32'h0, 1, 7, 16, 1, 0, 0, 0)));
    tbl.push_back(st(T_SEQ,  3'd1, B_WRAP8, 32'h00,        1'b1, mk(2, 32'h2, 2, 6, 16, 1, 0, 0, 0)));
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].e);
      apply(tbl[i].trans, tbl[i].size, tbl[i].burst, tbl[i].addr, tbl[i].ready);
      exp = exp_q.pop_front();
      obs = observe();
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got %s, required %s", i, fmt(obs), fmt(exp));
      end
      n_cmp++;
    end
    apply(T_IDLE, 3'd2, B_INCR, 32'h0, 1'b1);
  endtask

  initial begin
    bus.HTRANS = T_IDLE;
    bus.HSIZE  = 3'd0;
    bus.HBURST = B_SINGLE;
    bus.HADDR  = '0;
    bus.HREADY = 1'b1;
    #12;
    test_reset();
    test_incr4();
    test_wrap4();
    test_size_err();
    test_busy_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_burst_length_tracker.md
AHB_BURST_LENGTH_TRACKER -- requirements
Module: ahb_burst_length_tracker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus data width in bits (8..1024, power of two).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width in bits.
REQ-003 SHALL have port HCLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset; asynchronous assertion and active-low (fixed).
REQ-005 SHALL have port HTRANS  input  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-006 SHALL have port HSIZE  input  3  beat size code; bytes = 2^HSIZE.
REQ-007 SHALL have port HBURST  input  3  burst type: SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16 (000..111).
REQ-008 SHALL have port HADDR  input  ADDR_WIDTH  address-phase address.
REQ-009 SHALL have port HREADY  input  1  bus ready; address phase accepted only when high.
REQ-010 SHALL have port BEAT_BYTES  output  8  bytes per beat of the current burst.
REQ-011 SHALL have port NEXT_ADDR  output  ADDR_WIDTH  predicted address of the next beat.
REQ-012 SHALL have port BEAT_CNT  output  5  beats accepted in the current burst (1..16; saturates at 31 for INCR).
REQ-013 SHALL have port BEATS_LEFT  output  5  remaining beats; 0 for INCR and SINGLE.
REQ-014 SHALL have port TOTAL_BYTES  output  12  beats x BEAT_BYTES of the burst; 0 for INCR.
REQ-015 SHALL have ports BURST_ACTIVE, BURST_LAST, SIZE_ERR, SEQ_ERR  output  1 each  status flags.

Function
REQ-016 Accept SHALL mean HREADY=1 at a rising HCLK edge; with HREADY=0 all state and outputs hold.
REQ-017 FSM SHALL have states IDLE and ACTIVE; IDLE->ACTIVE on accepted NONSEQ; ACTIVE->IDLE on accepted IDLE.
REQ-018 Accepted NONSEQ (either state) SHALL restart: capture size, burst, address; BEAT_CNT=1; BEATS_LEFT=len-1 (len 1/4/8/16; 0 for INCR).
REQ-019 BEAT_BYTES SHALL equal 2^HSIZE; if 2^HSIZE > DATA_WIDTH/8, clamp to DATA_WIDTH/8 and pulse SIZE_ERR for one cycle.
REQ-020 Accepted SEQ in ACTIVE with BEATS_LEFT>0 or INCR SHALL increment BEAT_CNT, decrement BEATS_LEFT (not for INCR), advance NEXT_ADDR.
REQ-021 INCR types SHALL set NEXT_ADDR = current beat address + BEAT_BYTES, modulo 2^ADDR_WIDTH.
REQ-022 WRAP types SHALL set NEXT_ADDR = (addr & ~M) | ((addr + BEAT_BYTES) & M), M = len x BEAT_BYTES - 1.
REQ-023 BURST_LAST SHALL be 1 while ACTIVE, type fixed-length, BEATS_LEFT=0 (SINGLE included).
REQ-024 Accepted SEQ in IDLE, or with BURST_LAST=1, SHALL pulse SEQ_ERR one cycle and leave counters unchanged.
REQ-025 Accepted BUSY SHALL hold all counters, NEXT_ADDR and state.
REQ-026 All outputs SHALL be registered; values reflect an accept one cycle after the accepting edge.
REQ-027 SIZE_ERR and SEQ_ERR SHALL be single-cycle pulses, deasserted otherwise.

Reset
REQ-028 HRESETn=0 SHALL immediately force state IDLE and every output to 0, including mid-burst.
REQ-029 After release the first accepted NONSEQ SHALL behave as REQ-018; no burst context survives.

Structure
REQ-030 Package ahb_len_pkg SHALL hold htrans_t, hburst_t, state_t enums and burst-length constants (1/4/8/16).
REQ-031 Sub-module ahb_size_decoder (combinational, parametrised by DATA_WIDTH) SHALL map HSIZE to clamped bytes plus size-error flag.

Verification (DATA_WIDTH=32)
REQ-032 Reset: assert HRESETn=0 mid-INCR8 -> all outputs 0 same cycle; BURST_ACTIVE=0.
REQ-033 INCR4, HSIZE=010, HADDR=0x100, SEQ x3 -> NEXT_ADDR 0x104, 0x108, 0x10C, 0x110; BEAT_CNT 1..4; BURST_LAST on beat 4; TOTAL_BYTES=16.
REQ-034 WRAP4, HSIZE=010, HADDR=0x38 -> NEXT_ADDR 0x3C, 0x30, 0x34, 0x38; BEATS_LEFT 3,2,1,0.
REQ-035 NONSEQ HSIZE=011 -> SIZE_ERR one cycle, BEAT_BYTES=4.
REQ-036 INCR4 with BUSY and HREADY=0 cycles inserted after beat 2 -> counters frozen; extra SEQ after beat 4 -> SEQ_ERR pulse, BEAT_CNT stays 4.
